// File: rtl/clkdiv.sv
// ---------------------------------------------------------------------------
// clkdiv -- integer clock divider producing a registered, glitch-free
// divided clock whose period is exactly DIV cycles of sys_clk.
//
// The output sits low for LOW = DIV - floor(DIV/2) cycles and then high for
// HIGH = floor(DIV/2) cycles, so odd divisors get the longer low phase.
//
// Parameters
//   DIV      output period in sys_clk cycles, 2 .. 2^31-1
//
// Ports
//   rst      in   asynchronous active-high reset
//   sys_clk  in   source clock; all state changes on its rising edge
//   clk      out  divided clock, straight from a flop
//   tick     out  one-cycle strobe coinciding with each rise of clk
//                 (only present when CLKDIV_TICK_EN is defined)
//
// Optional feature
//   CLKDIV_TICK_EN  when defined, adds the tick port and its register.
//                   Without it the port list is exactly (rst, sys_clk, clk).
// ---------------------------------------------------------------------------
module clkdiv #(
  parameter int DIV = 50
) (
  input  logic rst,
  input  logic sys_clk,
  output logic clk
`ifdef CLKDIV_TICK_EN
  ,
  output logic tick
`endif
);

  // Counter is wide enough to hold DIV-1, but never narrower than one bit.
  localparam int CW   = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
  localparam int HIGH = DIV / 2;
  localparam int LOW  = DIV - HIGH;

  localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW);

  // A divisor below two cannot produce a clock; refuse to elaborate.
  if (DIV < 2) begin : gBadDiv
    $error("clkdiv: DIV must be at least 2, got %0d", DIV);
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clk_q;
  logic          clk_d;

  // The output level is decided from the counter value it is about to take,
  // so clk and cnt move together and the first rise lands on edge LOW.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST_C) begin
      cnt_d = '0;
    end
    clk_d = (cnt_d >= LOW_C);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk = clk_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q;
  logic tick_d;

  // A rise of clk is seen one edge early as clk_d=1 while clk_q=0, so the
  // strobe register becomes high in exactly the cycle clk goes high.
  always_comb begin
    tick_d = clk_d & ~clk_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clkdiv.sv
// ---------------------------------------------------------------------------
// tb_clkdiv -- self-checking bench for clkdiv.
//
// Four dividers (DIV = 50, 2, 5, 7) share one reset and one source clock.
// The expected output level is computed from the number of sys_clk rising
// edges seen since reset release: with k edges, clk is high exactly when
// (k mod DIV) >= DIV - floor(DIV/2), and tick is high when k mod DIV equals
// that threshold. Outputs are sampled on the falling edge of sys_clk.
// ---------------------------------------------------------------------------
module tb_clkdiv;

  logic   rst;
  logic   sys_clk;
  logic   clk50;
  logic   clk2;
  logic   clk5;
  logic   clk7;
`ifdef CLKDIV_TICK_EN
  logic   tick50;
  logic   tick2;
  logic   tick5;
  logic   tick7;
`endif

  int     nChecks = 0;
  int     nFail   = 0;
  longint k       = 0;

  clkdiv #(.DIV(50)) uDiv50 (
    .rst(rst), .sys_clk(sys_clk), .clk(clk50)
`ifdef CLKDIV_TICK_EN
    , .tick(tick50)
`endif
  );

  clkdiv #(.DIV(2)) uDiv2 (
    .rst(rst), .sys_clk(sys_clk), .clk(clk2)
`ifdef CLKDIV_TICK_EN
    , .tick(tick2)
`endif
  );

  clkdiv #(.DIV(5)) uDiv5 (
    .rst(rst), .sys_clk(sys_clk), .clk(clk5)
`ifdef CLKDIV_TICK_EN
    , .tick(tick5)
`endif
  );

  clkdiv #(.DIV(7)) uDiv7 (
    .rst(rst), .sys_clk(sys_clk), .clk(clk7)
`ifdef CLKDIV_TICK_EN
    , .tick(tick7)
`endif
  );

  // Source clock: rising edges at 5, 15, 25, ...; sampling on falling edges.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Reference model: level of the divided clock after kk edges.
  function automatic logic expClk(int div, longint kk);
    longint lowLen;
    lowLen = longint'(div - div / 2);
    if (kk <= 0) return 1'b0;
    return ((kk % longint'(div)) >= lowLen);
  endfunction

  // Reference model: strobe after kk edges, one per period on the rise.
  function automatic logic expTick(int div, longint kk);
    longint lowLen;
    lowLen = longint'(div - div / 2);
    if (kk <= 0) return 1'b0;
    return ((kk % longint'(div)) == lowLen);
  endfunction

  // Advance one source edge and settle at the following falling edge.
  task automatic stepEdge();
    @(posedge sys_clk);
    if (!rst) k++;
    @(negedge sys_clk);
  endtask

  // Pulse reset for a couple of cycles and release it between edges.
  task automatic restart();
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    nChecks++;
    if (clk50 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_clk50 got=%b expected=0", clk50); end
    nChecks++;
    if (clk2 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_clk2 got=%b expected=0", clk2); end
    nChecks++;
    if (clk5 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_clk5 got=%b expected=0", clk5); end
    nChecks++;
    if (clk7 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_clk7 got=%b expected=0", clk7); end
`ifdef CLKDIV_TICK_EN
    nChecks++;
    if ({tick50, tick2, tick5, tick7} !== 4'b0000) begin
      nFail++; $display("[TB] FAIL reset_tick got=%b expected=0000", {tick50, tick2, tick5, tick7});
    end
`endif
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic test_div50();
    int   rises;
    int   firstRise;
    logic prev;
    rises     = 0;
    firstRise = -1;
    restart();
    prev = clk50;
    for (int i = 0; i < 500; i++) begin
      stepEdge();
      nChecks++;
      if (clk50 !== expClk(50, k)) begin
        nFail++; $display("[TB] FAIL div50_wave k=%0d got=%b expected=%b", k, clk50, expClk(50, k));
      end
      if (prev === 1'b0 && clk50 === 1'b1) begin
        rises++;
        if (firstRise < 0) firstRise = int'(k);
      end
      prev = clk50;
    end
    nChecks++;
    if (rises != 10) begin nFail++; $display("[TB] FAIL div50_rises got=%0d expected=10", rises); end
    nChecks++;
    if (firstRise != 25) begin nFail++; $display("[TB] FAIL div50_first_rise got=%0d expected=25", firstRise); end
  endtask

  task automatic test_div2();
    logic prev;
    restart();
    prev = clk2;
    for (int i = 0; i < 20; i++) begin
      stepEdge();
      nChecks++;
      if (clk2 !== ((k % 2) == 1)) begin
        nFail++; $display("[TB] FAIL div2_level k=%0d got=%b expected=%b", k, clk2, (k % 2) == 1);
      end
      nChecks++;
      if (clk2 === prev) begin
        nFail++; $display("[TB] FAIL div2_toggle k=%0d got=%b expected=%b", k, clk2, ~prev);
      end
      prev = clk2;
    end
  endtask

  task automatic test_div5();
    int   highs;
    int   rises;
    logic prev;
    highs = 0;
    rises = 0;
    restart();
    prev = clk5;
    for (int i = 0; i < 500; i++) begin
      stepEdge();
      nChecks++;
      if (clk5 !== expClk(5, k)) begin
        nFail++; $display("[TB] FAIL div5_wave k=%0d got=%b expected=%b", k, clk5, expClk(5, k));
      end
      if (clk5 === 1'b1) highs++;
      if (prev === 1'b0 && clk5 === 1'b1) rises++;
      prev = clk5;
    end
    nChecks++;
    if (highs != 200) begin nFail++; $display("[TB] FAIL div5_high_cycles got=%0d expected=200", highs); end
    nChecks++;
    if (rises != 100) begin nFail++; $display("[TB] FAIL div5_rises got=%0d expected=100", rises); end
  endtask

  task automatic test_async_reset();
    bit   found;
    logic prev;
    found = 1'b0;
    restart();
    for (int i = 0; i < 60 && !found; i++) begin
      stepEdge();
      if (clk50 === 1'b1) found = 1'b1;
    end
    nChecks++;
    if (!found) begin nFail++; $display("[TB] FAIL async_wait_high got=timeout expected=clk50 high within 60 edges"); end
    #2;
    rst = 1'b1;
    #1;
    nChecks++;
    if (clk50 !== 1'b0) begin nFail++; $display("[TB] FAIL async_clear got=%b expected=0", clk50); end
    @(negedge sys_clk);
    @(negedge sys_clk);
    nChecks++;
    if (clk50 !== 1'b0) begin nFail++; $display("[TB] FAIL async_hold got=%b expected=0", clk50); end
    rst = 1'b0;
    k   = 0;
    prev = clk50;
    for (int i = 0; i < 30; i++) begin
      stepEdge();
      nChecks++;
      if (clk50 !== expClk(50, k)) begin
        nFail++; $display("[TB] FAIL async_restart k=%0d got=%b expected=%b", k, clk50, expClk(50, k));
      end
      if (k == 25) begin
        nChecks++;
        if (!(prev === 1'b0 && clk50 === 1'b1)) begin
          nFail++; $display("[TB] FAIL async_rise_at_25 got=%b->%b expected=0->1", prev, clk50);
        end
      end
      prev = clk50;
    end
  endtask

  task automatic test_random();
    int runLen;
    int offset;
    int hold;
    restart();
    for (int seg = 0; seg < 15; seg++) begin
      runLen = int'($urandom_range(1, 120));
      for (int i = 0; i < runLen; i++) begin
        stepEdge();
        nChecks++;
        if ({clk50, clk2, clk5, clk7} !== {expClk(50, k), expClk(2, k), expClk(5, k), expClk(7, k)}) begin
          nFail++;
          $display("[TB] FAIL random_clk k=%0d got=%b expected=%b", k, {clk50, clk2, clk5, clk7},
                   {expClk(50, k), expClk(2, k), expClk(5, k), expClk(7, k)});
        end
`ifdef CLKDIV_TICK_EN
        nChecks++;
        if ({tick50, tick2, tick5, tick7} !== {expTick(50, k), expTick(2, k), expTick(5, k), expTick(7, k)}) begin
          nFail++;
          $display("[TB] FAIL random_tick k=%0d got=%b expected=%b", k, {tick50, tick2, tick5, tick7},
                   {expTick(50, k), expTick(2, k), expTick(5, k), expTick(7, k)});
        end
`endif
      end
      offset = int'($urandom_range(1, 3));
      #(offset);
      rst = 1'b1;
      #1;
      nChecks++;
      if ({clk50, clk2, clk5, clk7} !== 4'b0000) begin
        nFail++; $display("[TB] FAIL random_async_clear seg=%0d got=%b expected=0000", seg, {clk50, clk2, clk5, clk7});
      end
      hold = int'($urandom_range(0, 2));
      @(negedge sys_clk);
      repeat (hold) @(negedge sys_clk);
      rst = 1'b0;
      k   = 0;
    end
  endtask

`ifdef CLKDIV_TICK_EN
  task automatic test_tick();
    int   pulses;
    logic prev;
    pulses = 0;
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      nChecks++;
      if (tick7 !== 1'b0) begin nFail++; $display("[TB] FAIL tick_in_reset got=%b expected=0", tick7); end
    end
    rst = 1'b0;
    k   = 0;
    prev = clk7;
    for (int i = 0; i < 70; i++) begin
      stepEdge();
      nChecks++;
      if (tick7 !== expTick(7, k)) begin
        nFail++; $display("[TB] FAIL tick7_pulse k=%0d got=%b expected=%b", k, tick7, expTick(7, k));
      end
      nChecks++;
      if (tick7 !== (prev === 1'b0 && clk7 === 1'b1)) begin
        nFail++; $display("[TB] FAIL tick7_align k=%0d got=%b expected=%b", k, tick7, prev === 1'b0 && clk7 === 1'b1);
      end
      if (tick7 === 1'b1) pulses++;
      prev = clk7;
    end
    nChecks++;
    if (pulses != 10) begin nFail++; $display("[TB] FAIL tick7_count got=%0d expected=10", pulses); end
  endtask
`endif

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_div50();
    test_div2();
    test_div5();
    test_async_reset();
    test_random();
`ifdef CLKDIV_TICK_EN
    test_tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
